// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Frame-capture, status and read-handshake bundle for uart_rx_fifo.
//            Build macro UART_RX_FIFO_ERR_TAG_EN adds read_error_tag.
// Revision : 1.0  initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int ERR_COUNT_WIDTH = 8
);
    localparam int c_FILL_W = $clog2(FIFO_DEPTH) + 1;

    logic                       data_valid;
    logic [DATA_WIDTH-1:0]      parallel_data;
    logic                       parity_error;
    logic                       frame_error;
    logic                       read_enable;
    logic                       clear_errors;
    logic [DATA_WIDTH-1:0]      read_data;
    logic                       read_data_valid;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [c_FILL_W-1:0]        fill_level;
    logic                       overflow;
    logic [1:0]                 error_sticky;
    logic [ERR_COUNT_WIDTH-1:0] error_count;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic [1:0]                 read_error_tag;
`endif

    modport master (
`ifdef UART_RX_FIFO_ERR_TAG_EN
        input  read_error_tag,
`endif
        output data_valid, parallel_data, parity_error, frame_error,
        output read_enable, clear_errors,
        input  read_data, read_data_valid, fifo_empty, fifo_full, fill_level,
        input  overflow, error_sticky, error_count
    );

    modport slave (
`ifdef UART_RX_FIFO_ERR_TAG_EN
        output read_error_tag,
`endif
        input  data_valid, parallel_data, parity_error, frame_error,
        input  read_enable, clear_errors,
        output read_data, read_data_valid, fifo_empty, fifo_full, fill_level,
        output overflow, error_sticky, error_count
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receive FIFO with sticky error flags and a saturating
//            error-event counter. Build macro UART_RX_FIFO_ERR_TAG_EN also
//            stores errored frames with a {frame, parity} tag.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int ERR_COUNT_WIDTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus
);
    localparam int                         c_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int                         c_FILL_W  = c_ADDR_W + 1;
    localparam logic [c_FILL_W-1:0]        c_DEPTH   = c_FILL_W'(FIFO_DEPTH);
    localparam logic [ERR_COUNT_WIDTH-1:0] c_CNT_MAX = '1;

    logic [DATA_WIDTH-1:0]      r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0]        r_wr_ptr;
    logic [c_ADDR_W-1:0]        r_rd_ptr;
    logic [c_FILL_W-1:0]        r_fill;
    logic [c_FILL_W-1:0]        w_fill_next;
    logic                       r_empty;
    logic                       r_full;
    logic [DATA_WIDTH-1:0]      r_read_data;
    logic                       r_read_data_valid;
    logic                       r_overflow;
    logic [1:0]                 r_err_sticky;
    logic [ERR_COUNT_WIDTH-1:0] r_err_count;
    logic                       r_err_prev;

    logic                       w_err_any;
    logic                       w_err_event;
    logic [1:0]                 w_err_bits;
    logic                       w_wr_req;
    logic                       w_rd_accept;
    logic                       w_wr_accept;
    logic                       w_drop;

    assign w_err_any   = bus.parity_error | bus.frame_error;
    assign w_err_event = w_err_any & ~r_err_prev;
    assign w_err_bits  = {bus.frame_error, bus.parity_error};

`ifdef UART_RX_FIFO_ERR_TAG_EN
    logic [1:0] r_tag_mem [FIFO_DEPTH];
    logic [1:0] r_read_error_tag;
    logic [1:0] w_wr_tag;

    assign w_wr_req = bus.data_valid | w_err_event;
    assign w_wr_tag = w_err_event ? w_err_bits : 2'b00;
`else
    assign w_wr_req = bus.data_valid;
`endif

    // A pop frees a slot on the same edge, so a full FIFO still accepts a write.
    assign w_rd_accept = bus.read_enable & ~r_empty;
    assign w_wr_accept = w_wr_req & (~r_full | w_rd_accept);
    assign w_drop      = w_wr_req & r_full & ~w_rd_accept;

    always_comb begin
        w_fill_next = r_fill;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_fill_next = r_fill + c_FILL_W'(1);
            2'b01:   w_fill_next = r_fill - c_FILL_W'(1);
            default: w_fill_next = r_fill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= bus.parallel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr          <= '0;
            r_rd_ptr          <= '0;
            r_fill            <= '0;
            r_empty           <= 1'b1;
            r_full            <= 1'b0;
            r_read_data       <= '0;
            r_read_data_valid <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr    <= r_rd_ptr + c_ADDR_W'(1);
                r_read_data <= r_mem[r_rd_ptr];
            end
            r_read_data_valid <= w_rd_accept;
            r_fill            <= w_fill_next;
            r_empty           <= (w_fill_next == '0);
            r_full            <= (w_fill_next == c_DEPTH);
        end
    end

`ifdef UART_RX_FIFO_ERR_TAG_EN
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_tag_mem[r_wr_ptr] <= w_wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_read_error_tag <= 2'b00;
        end else if (w_rd_accept) begin
            r_read_error_tag <= r_tag_mem[r_rd_ptr];
        end
    end

    assign bus.read_error_tag = r_read_error_tag;
`endif

    // A new event or drop on the clearing edge survives the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err_prev   <= 1'b0;
            r_overflow   <= 1'b0;
            r_err_sticky <= 2'b00;
            r_err_count  <= '0;
        end else begin
            r_err_prev <= w_err_any;
            if (bus.clear_errors) begin
                r_overflow   <= w_drop;
                r_err_sticky <= w_err_event ? w_err_bits : 2'b00;
                r_err_count  <= w_err_event ? ERR_COUNT_WIDTH'(1) : '0;
            end else begin
                r_overflow <= r_overflow | w_drop;
                if (w_err_event) begin
                    r_err_sticky <= r_err_sticky | w_err_bits;
                    if (r_err_count != c_CNT_MAX) begin
                        r_err_count <= r_err_count + ERR_COUNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign bus.read_data       = r_read_data;
    assign bus.read_data_valid = r_read_data_valid;
    assign bus.fifo_empty      = r_empty;
    assign bus.fifo_full       = r_full;
    assign bus.fill_level      = r_fill;
    assign bus.overflow        = r_overflow;
    assign bus.error_sticky    = r_err_sticky;
    assign bus.error_count     = r_err_count;
endmodule
`default_nettype wire
